// File: rtl/meta_ctrl_pkg.sv
// rtl/meta_ctrl_pkg.sv - shared types and defaults for the window calibration block
package meta_ctrl_pkg;

  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned SETTLE_CYC_DEF = 4;
  localparam int unsigned WIN_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_MEAS   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // A sweep with an empty window range or zero-length measurement has nothing to do.
  function automatic logic cfg_illegal(input logic [WIN_W-1:0] lo,
                                       input logic [WIN_W-1:0] hi,
                                       input logic             len_zero);
    return (lo > hi) || len_zero;
  endfunction

endpackage

// File: rtl/meta_err_cnt.sv
// rtl/meta_err_cnt.sv - saturating error event counter
module meta_err_cnt
  import meta_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/meta_win_cal.sv
// rtl/meta_win_cal.sv - sweeps detector window settings and reports the first one
// whose error count over a measurement interval reaches the threshold
module meta_win_cal
  import meta_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_lo,
  input  logic [WIN_W-1:0] win_hi,
  input  logic [CNT_W-1:0] meas_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             error,
  output logic [WIN_W-1:0] win_sel,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIN_W-1:0] res_win,
  output logic [CNT_W-1:0] res_cnt
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_e           state_q;
  logic [WIN_W-1:0] win_sel_q;
  logic [WIN_W-1:0] win_hi_q;
  logic [WIN_W-1:0] res_win_q;
  logic [CNT_W-1:0] meas_len_q;
  logic [CNT_W-1:0] thresh_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] res_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;

  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;
  logic             err_inc;

  // The counter is held clear for the whole settle period so glitches while the
  // detector re-locks never leak into the measurement.
  assign err_clr = (state_q == ST_SETTLE);
  assign err_inc = (state_q == ST_MEAS) && error;

  meta_err_cnt #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (err_clr),
    .inc  (err_inc),
    .cnt  (err_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_sel_q  <= '0;
      win_hi_q   <= '0;
      res_win_q  <= '0;
      meas_len_q <= '0;
      thresh_q   <= '0;
      cyc_q      <= '0;
      res_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != ST_IDLE) && abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        found_q <= 1'b0;
        cyc_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              win_hi_q   <= win_hi;
              meas_len_q <= meas_len;
              thresh_q   <= thresh;
              found_q    <= 1'b0;
              res_win_q  <= '0;
              res_cnt_q  <= '0;
              cyc_q      <= '0;
              busy_q     <= 1'b1;
              if (cfg_illegal(win_lo, win_hi, meas_len == '0)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                win_sel_q <= win_lo;
                state_q   <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            if (cyc_q == SETTLE_LAST) begin
              cyc_q   <= '0;
              state_q <= ST_MEAS;
            end else begin
              cyc_q <= cyc_q + ONE;
            end
          end
          ST_MEAS: begin
            if (cyc_q == (meas_len_q - ONE)) begin
              cyc_q   <= '0;
              state_q <= ST_EVAL;
            end else begin
              cyc_q <= cyc_q + ONE;
            end
          end
          ST_EVAL: begin
            if (err_cnt >= thresh_q) begin
              found_q   <= 1'b1;
              res_win_q <= win_sel_q;
              res_cnt_q <= err_cnt;
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
            end else if (win_sel_q == win_hi_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              // win_hi_q <= 15 so this increment can never wrap
              win_sel_q <= win_sel_q + WIN_W'(1);
              state_q   <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign win_sel = win_sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign res_win = res_win_q;
  assign res_cnt = res_cnt_q;

endmodule

// File: tb/tb_meta_win_cal.sv
// tb/tb_meta_win_cal.sv - self-checking bench for meta_win_cal
module tb_meta_win_cal;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  win_lo = '0;
  logic [3:0]  win_hi = '0;
  logic [15:0] meas_len = '0;
  logic [15:0] thresh = '0;
  logic        error = 1'b0;
  logic [3:0]  win_sel;
  logic        busy, done, found;
  logic [3:0]  res_win;
  logic [15:0] res_cnt;

  logic        start4 = 1'b0;
  logic        abort4 = 1'b0;
  logic [3:0]  win_lo4 = '0;
  logic [3:0]  win_hi4 = '0;
  logic [3:0]  meas_len4 = '0;
  logic [3:0]  thresh4 = '0;
  logic        error4 = 1'b0;
  logic [3:0]  win_sel4;
  logic        busy4, done4, found4;
  logic [3:0]  res_win4;
  logic [3:0]  res_cnt4;

  always #5 clk = ~clk;

  meta_win_cal dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .win_lo(win_lo), .win_hi(win_hi), .meas_len(meas_len), .thresh(thresh),
    .error(error), .win_sel(win_sel), .busy(busy), .done(done),
    .found(found), .res_win(res_win), .res_cnt(res_cnt)
  );

  meta_win_cal #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .win_lo(win_lo4), .win_hi(win_hi4), .meas_len(meas_len4), .thresh(thresh4),
    .error(error4), .win_sel(win_sel4), .busy(busy4), .done(done4),
    .found(found4), .res_win(res_win4), .res_cnt(res_cnt4)
  );

  typedef struct {
    string name;
    int lo, hi, len, th, mode, ew, en;
    int e_k, e_found, e_rw, e_rc, e_ws;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int mcnt[16];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // mode 0: error low, 1: error high, 2: en-cycle burst at start of window ew's
  // measurement, 3: random. Records per-window error counts seen during measurement.
  task automatic run_sweep(input int lo, input int hi, input int len, input int th,
                           input int mode, input int ew, input int en,
                           output int done_k, output int pulses, output int trace_bad);
    int p, idx, w, per, limit;
    bit meas;
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    per = S + len + 1;
    limit = 16 * per + 4;
    done_k = -1; pulses = 0; trace_bad = 0;
    win_lo = 4'(lo); win_hi = 4'(hi); meas_len = 16'(len); thresh = 16'(th);
    error = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      p = (k - 1) % per;
      idx = (k - 1) / per;
      w = lo + idx;
      meas = (p >= S) && (p < S + len);
      case (mode)
        0: error = 1'b0;
        1: error = 1'b1;
        2: error = (w == ew) && meas && ((p - S) < en);
        default: error = 1'($urandom_range(0, 1));
      endcase
      if (meas && error && w < 16) mcnt[w]++;
      @(negedge clk);
      if (done) begin
        pulses++;
        if (done_k < 0) done_k = k;
      end
      if (done_k < 0 && meas && lo <= hi && win_sel != 4'(w)) trace_bad++;
      if (done_k < 0 && !busy) trace_bad++;
      if (done_k >= 0 && k == done_k + 1) begin
        if (busy) trace_bad++;
        break;
      end
      @(posedge clk); #1;
    end
    error = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int dk, pulses, tbad, lo, hi, len, th, nwin, per;
    int e_found, e_k, e_rw, e_rc, e_ws;

    vecs[0] = '{"normal",       2,  5, 8, 3, 2, 4, 4,  40, 1,  4, 4,  4};
    vecs[1] = '{"no_find",      0, 15, 2, 1, 0, 0, 0, 113, 0,  0, 0, 15};
    vecs[2] = '{"thresh0",      5,  9, 3, 0, 0, 0, 0,   9, 1,  5, 0,  5};
    vecs[3] = '{"illegal",      7,  3, 8, 1, 0, 0, 0,   1, 0,  0, 0,  5};
    vecs[4] = '{"len0",         1,  2, 0, 1, 0, 0, 0,   1, 0,  0, 0,  5};
    vecs[5] = '{"all_err_miss", 3,  6, 4, 5, 1, 0, 0,  37, 0,  0, 0,  6};
    vecs[6] = '{"all_err_hit", 10, 12, 4, 4, 1, 0, 0,  10, 1, 10, 4, 10};
    vecs[7] = '{"exact_thresh", 0,  2, 6, 3, 2, 1, 3,  23, 1,  1, 3,  1};

    #1 rst_n = 1'b0;
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_found", int'(found), 0);
    chk("reset_win_sel", int'(win_sel), 0);
    chk("reset_res_win", int'(res_win), 0);
    chk("reset_res_cnt", int'(res_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_sweep(vecs[i].lo, vecs[i].hi, vecs[i].len, vecs[i].th,
                vecs[i].mode, vecs[i].ew, vecs[i].en, dk, pulses, tbad);
      chk({vecs[i].name, "_done_cycle"}, dk, vecs[i].e_k);
      chk({vecs[i].name, "_done_pulses"}, pulses, 1);
      chk({vecs[i].name, "_found"}, int'(found), vecs[i].e_found);
      chk({vecs[i].name, "_res_win"}, int'(res_win), vecs[i].e_rw);
      chk({vecs[i].name, "_res_cnt"}, int'(res_cnt), vecs[i].e_rc);
      chk({vecs[i].name, "_win_sel"}, int'(win_sel), vecs[i].e_ws);
      chk({vecs[i].name, "_trace"}, tbad, 0);
    end

    // start while busy: second pulse with a different range must be ignored
    win_lo = 4'd2; win_hi = 4'd3; meas_len = 16'd2; thresh = 16'd1; error = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dk = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 3) begin
        win_lo = 4'd0; win_hi = 4'd15; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done && dk < 0) begin
        dk = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_start_done_cycle", dk, 15);
    chk("busy_start_win_sel", int'(win_sel), 3);
    @(posedge clk); #1;

    // abort in window 1's measurement (cycle 16 for len 5)
    win_lo = 4'd0; win_hi = 4'd3; meas_len = 16'd5; thresh = 16'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_pre_win_sel", int'(win_sel), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_found", int'(found), 0);
    chk("abort_win_sel", int'(win_sel), 1);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_stays_idle", pulses, 0);

    // reset during settle, then a full sweep
    win_lo = 4'd6; win_hi = 4'd8; meas_len = 16'd3; thresh = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_win_sel", int'(win_sel), 0);
    chk("mid_reset_done_found", int'(done) + int'(found), 0);
    @(negedge clk) rst_n = 1'b1;
    run_sweep(1, 2, 3, 2, 1, 0, 0, dk, pulses, tbad);
    chk("post_reset_done_cycle", dk, 9);
    chk("post_reset_found", int'(found), 1);
    chk("post_reset_res_win", int'(res_win), 1);
    chk("post_reset_res_cnt", int'(res_cnt), 3);
    chk("post_reset_trace", tbad, 0);

    // saturation limit on the 4-bit instance
    win_lo4 = 4'd3; win_hi4 = 4'd5; meas_len4 = 4'd15; thresh4 = 4'd15; error4 = 1'b1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    dk = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (done4) begin
        dk = k;
        break;
      end
      @(posedge clk); #1;
    end
    error4 = 1'b0;
    chk("sat_done_cycle", dk, 21);
    chk("sat_found", int'(found4), 1);
    chk("sat_res_win", int'(res_win4), 3);
    chk("sat_res_cnt", int'(res_cnt4), 15);
    @(posedge clk); #1;

    // random sweeps against a window-by-window count model
    for (int r = 0; r < 12; r++) begin
      lo = $urandom_range(0, 15);
      hi = lo + $urandom_range(0, 3);
      if (hi > 15) hi = 15;
      len = $urandom_range(1, 5);
      th = $urandom_range(0, 4);
      run_sweep(lo, hi, len, th, 3, 0, 0, dk, pulses, tbad);
      per = S + len + 1;
      nwin = hi - lo + 1;
      e_found = 0; e_rw = 0; e_rc = 0; e_ws = hi; e_k = nwin * per + 1;
      for (int i = 0; i < nwin; i++) begin
        if (mcnt[lo + i] >= th) begin
          e_found = 1; e_rw = lo + i; e_rc = mcnt[lo + i]; e_ws = lo + i;
          e_k = (i + 1) * per + 1;
          break;
        end
      end
      chk($sformatf("rand%0d_done_cycle", r), dk, e_k);
      chk($sformatf("rand%0d_done_pulses", r), pulses, 1);
      chk($sformatf("rand%0d_found", r), int'(found), e_found);
      chk($sformatf("rand%0d_res_win", r), int'(res_win), e_rw);
      chk($sformatf("rand%0d_res_cnt", r), int'(res_cnt), e_rc);
      chk($sformatf("rand%0d_win_sel", r), int'(win_sel), e_ws);
      chk($sformatf("rand%0d_trace", r), tbad, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
